coo_row_scheduler: RTL and testbench

Sequencer in front of the COO sparse matmul datapath. Accepts the nonzeros of sparse matrix X as a row-major stream of COO beats (value, row, col), packs each row into a zero-padded batch of at most NZN_ROW entries, and issues exactly N row batches per matrix, in row order and including empty rows, to the per-row dot-product engines. Detects per-row overflow and out-of-order rows.

---
 rtl/coo_pkg.sv | 26 ++
 rtl/coo_row_scheduler_if.sv | 44 ++++
 rtl/coo_row_buffer.sv | 79 +++++++
 rtl/coo_row_scheduler.sv | 179 +++++++++++++++++
 tb/tb_coo_row_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coo_pkg.sv
// coo_pkg: shared types for the COO row scheduler.
//   coo_entry_t  - one sparse nonzero (value, row, column)
//   state_e      - scheduler FSM states
//   cnt_width()  - width of a 0..nzn_row slot counter
// Entry field widths are fixed here; scheduler DATA_WIDTH/ADDR_WIDTH must match them.
package coo_pkg;

   localparam int unsigned CooDataWidth = 8;
   localparam int unsigned CooAddrWidth = 16;

   typedef struct packed {
      logic [CooDataWidth-1:0] data;
      logic [CooAddrWidth-1:0] row;
      logic [CooAddrWidth-1:0] col;
   } coo_entry_t;

   typedef enum logic {
      StCollect = 1'b0,
      StEmit    = 1'b1
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned nzn_row);
      return $clog2(nzn_row + 1);
   endfunction

endpackage

// File: rtl/coo_row_scheduler_if.sv
// coo_row_scheduler_if: COO beat input stream and row-batch output stream.
//   in_*   : value/row/col/keep/last beat with valid/ready handshake
//   out_*  : packed batch (data, col, count, row, last) with valid/ready handshake
// Modports: slave = scheduler side, master = producer/consumer side.
interface coo_row_scheduler_if
   import coo_pkg::*;
#(
   parameter int unsigned NZN_ROW    = 2,
   parameter int unsigned DATA_WIDTH = CooDataWidth,
   parameter int unsigned ADDR_WIDTH = CooAddrWidth,
   parameter int unsigned CNT_W      = cnt_width(NZN_ROW)
);

   logic [DATA_WIDTH-1:0]              in_data;
   logic [ADDR_WIDTH-1:0]              in_row;
   logic [ADDR_WIDTH-1:0]              in_col;
   logic                               in_keep;
   logic                               in_last;
   logic                               in_valid;
   logic                               in_ready;

   logic [NZN_ROW-1:0][DATA_WIDTH-1:0] out_data;
   logic [NZN_ROW-1:0][ADDR_WIDTH-1:0] out_col;
   logic [CNT_W-1:0]                   out_count;
   logic [ADDR_WIDTH-1:0]              out_row;
   logic                               out_last;
   logic                               out_valid;
   logic                               out_ready;

   modport slave (
      input  in_data, in_row, in_col, in_keep, in_last, in_valid,
      output in_ready,
      output out_data, out_col, out_count, out_row, out_last, out_valid,
      input  out_ready
   );

   modport master (
      output in_data, in_row, in_col, in_keep, in_last, in_valid,
      input  in_ready,
      input  out_data, out_col, out_count, out_row, out_last, out_valid,
      output out_ready
   );

endinterface

// File: rtl/coo_row_buffer.sv
// coo_row_buffer: NZN_ROW-slot store for one row batch.
//   clk, rst     - clock, async active-high reset
//   i_clear      - zero all slots and count
//   i_append     - write (i_data, i_col) to slot[count], count++ (ignored when full)
//   i_load0      - zero all slots, then slot 0 = (i_data, i_col), count = 1
//   o_data/o_col - slot contents, unused slots 0
//   o_count      - number of valid slots; o_full - count == NZN_ROW
// Priority: load0 > clear > append.
module coo_row_buffer
   import coo_pkg::*;
#(
   parameter int unsigned NZN_ROW    = 2,
   parameter int unsigned DATA_WIDTH = CooDataWidth,
   parameter int unsigned ADDR_WIDTH = CooAddrWidth,
   parameter int unsigned CNT_W      = cnt_width(NZN_ROW)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_clear,
   input  logic                               i_append,
   input  logic                               i_load0,
   input  logic [DATA_WIDTH-1:0]              i_data,
   input  logic [ADDR_WIDTH-1:0]              i_col,
   output logic [NZN_ROW-1:0][DATA_WIDTH-1:0] o_data,
   output logic [NZN_ROW-1:0][ADDR_WIDTH-1:0] o_col,
   output logic [CNT_W-1:0]                   o_count,
   output logic                               o_full
);

   localparam logic [CNT_W-1:0] FullCount = CNT_W'(NZN_ROW);

   logic [NZN_ROW-1:0][DATA_WIDTH-1:0] r_data, w_data_nxt;
   logic [NZN_ROW-1:0][ADDR_WIDTH-1:0] r_col, w_col_nxt;
   logic [CNT_W-1:0]                   r_count, w_count_nxt;

   assign o_full = (r_count == FullCount);

   always_comb begin
      w_data_nxt  = r_data;
      w_col_nxt   = r_col;
      w_count_nxt = r_count;
      if (i_load0) begin
         w_data_nxt    = '0;
         w_col_nxt     = '0;
         w_data_nxt[0] = i_data;
         w_col_nxt[0]  = i_col;
         w_count_nxt   = CNT_W'(1);
      end else if (i_clear) begin
         w_data_nxt  = '0;
         w_col_nxt   = '0;
         w_count_nxt = '0;
      end else if (i_append && !o_full) begin
         for (int unsigned i = 0; i < NZN_ROW; i++) begin
            if (r_count == CNT_W'(i)) begin
               w_data_nxt[i] = i_data;
               w_col_nxt[i]  = i_col;
            end
         end
         w_count_nxt = r_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_col   <= '0;
         r_count <= '0;
      end else begin
         r_data  <= w_data_nxt;
         r_col   <= w_col_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign o_data  = r_data;
   assign o_col   = r_col;
   assign o_count = r_count;

endmodule

// File: rtl/coo_row_scheduler.sv
// coo_row_scheduler: packs a row-major COO nonzero stream into exactly N zero-padded
// row batches per matrix (empty rows included) for the per-row dot-product engines.
//   clk, rst      - clock, async active-high reset
//   bus (slave)   - in_* beat stream in, out_* row batches out
//   err_overflow  - sticky: an entry arrived for an already full row
//   err_order     - sticky: an entry arrived for an earlier row or a row >= N
// Build option: define COO_ROW_SCHED_ERR_EN to enable the order/range check and the
// sticky error flags. Without it the flags stay 0, earlier-row entries are treated as
// current-row entries, and overflow entries are still dropped.
module coo_row_scheduler
   import coo_pkg::*;
#(
   parameter int unsigned N          = 2,
   parameter int unsigned NZN_ROW    = 2,
   parameter int unsigned DATA_WIDTH = CooDataWidth,
   parameter int unsigned ADDR_WIDTH = CooAddrWidth
) (
   input  logic                clk,
   input  logic                rst,
   coo_row_scheduler_if.slave  bus,
   output logic                err_overflow,
   output logic                err_order
);

   localparam logic [ADDR_WIDTH-1:0] LastRow = ADDR_WIDTH'(N - 1);
   localparam logic [ADDR_WIDTH:0]   NumRows = (ADDR_WIDTH + 1)'(N);
`ifdef COO_ROW_SCHED_ERR_EN
   localparam logic ErrEn = 1'b1;
`else
   localparam logic ErrEn = 1'b0;
`endif

   state_e                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cur_row, w_cur_row_nxt;
   logic                  r_pend_valid, w_pend_valid_nxt;
   coo_entry_t            r_pend_entry, w_pend_entry_nxt;
   logic                  r_pend_last, w_pend_last_nxt;
   logic                  r_final, w_final_nxt;
   logic                  r_err_overflow, w_err_overflow_nxt;
   logic                  r_err_order, w_err_order_nxt;

   logic                  w_buf_clear, w_buf_append, w_buf_load0, w_buf_full;
   logic                  w_accept, w_handshake, w_out_last;
   logic                  w_row_bad, w_row_ahead;
   logic [ADDR_WIDTH-1:0] w_row_inc;

   assign w_accept    = (r_state == StCollect) && bus.in_valid;
   assign w_handshake = (r_state == StEmit) && bus.out_ready;
   assign w_out_last  = (r_state == StEmit) && (r_cur_row == LastRow);
   assign w_row_inc   = r_cur_row + ADDR_WIDTH'(1);

`ifdef COO_ROW_SCHED_ERR_EN
   assign w_row_bad   = (bus.in_row < r_cur_row) || ({1'b0, bus.in_row} >= NumRows);
   assign w_row_ahead = !w_row_bad && (bus.in_row > r_cur_row);
`else
   // Without the check, anything not ahead of cur_row lands in the current row.
   assign w_row_bad   = 1'b0;
   assign w_row_ahead = (bus.in_row > r_cur_row);
`endif

   always_comb begin
      w_state_nxt        = r_state;
      w_cur_row_nxt      = r_cur_row;
      w_pend_valid_nxt   = r_pend_valid;
      w_pend_entry_nxt   = r_pend_entry;
      w_pend_last_nxt    = r_pend_last;
      w_final_nxt        = r_final;
      w_err_overflow_nxt = r_err_overflow;
      w_err_order_nxt    = r_err_order;
      w_buf_clear        = 1'b0;
      w_buf_append       = 1'b0;
      w_buf_load0        = 1'b0;

      unique case (r_state)
         StCollect: begin
            if (w_accept) begin
               if (bus.in_keep) begin
                  if (w_row_bad) begin
                     w_err_order_nxt = ErrEn;
                  end else if (w_row_ahead) begin
                     // First beat of a later row: park it and close the current row.
                     w_pend_valid_nxt = 1'b1;
                     w_pend_entry_nxt = '{data: bus.in_data, row: bus.in_row,
                                          col: bus.in_col};
                     w_pend_last_nxt  = bus.in_last;
                     w_state_nxt      = StEmit;
                  end else begin
                     w_buf_append = 1'b1;
                     if (w_buf_full) begin
                        w_err_overflow_nxt = r_err_overflow | ErrEn;
                     end
                  end
               end
               // A parked last beat sets final only when it is loaded into its row.
               if (bus.in_last && !(bus.in_keep && w_row_ahead)) begin
                  w_final_nxt = 1'b1;
                  w_state_nxt = StEmit;
               end
            end
         end

         StEmit: begin
            if (w_handshake) begin
               w_buf_clear   = 1'b1;
               w_cur_row_nxt = w_row_inc;
               if (w_out_last) begin
                  w_cur_row_nxt    = '0;
                  w_final_nxt      = 1'b0;
                  w_pend_valid_nxt = 1'b0;
                  w_state_nxt      = StCollect;
               end else if (r_final) begin
                  w_state_nxt = StEmit;
               end else if (r_pend_valid && (r_pend_entry.row == w_row_inc)) begin
                  w_buf_load0      = 1'b1;
                  w_pend_valid_nxt = 1'b0;
                  if (r_pend_last) begin
                     w_final_nxt = 1'b1;
                  end else begin
                     w_state_nxt = StCollect;
                  end
               end else if (r_pend_valid) begin
                  // Row gap: emit empty batches until the parked row comes up.
                  w_state_nxt = StEmit;
               end else begin
                  w_state_nxt = StCollect;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= StCollect;
         r_cur_row      <= '0;
         r_pend_valid   <= 1'b0;
         r_pend_entry   <= '0;
         r_pend_last    <= 1'b0;
         r_final        <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_order    <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cur_row      <= w_cur_row_nxt;
         r_pend_valid   <= w_pend_valid_nxt;
         r_pend_entry   <= w_pend_entry_nxt;
         r_pend_last    <= w_pend_last_nxt;
         r_final        <= w_final_nxt;
         r_err_overflow <= w_err_overflow_nxt;
         r_err_order    <= w_err_order_nxt;
      end
   end

   coo_row_buffer #(
      .NZN_ROW    (NZN_ROW),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_row_buffer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_buf_clear),
      .i_append (w_buf_append),
      .i_load0  (w_buf_load0),
      .i_data   (w_buf_load0 ? r_pend_entry.data : bus.in_data),
      .i_col    (w_buf_load0 ? r_pend_entry.col : bus.in_col),
      .o_data   (bus.out_data),
      .o_col    (bus.out_col),
      .o_count  (bus.out_count),
      .o_full   (w_buf_full)
   );

   assign bus.in_ready  = (r_state == StCollect);
   assign bus.out_valid = (r_state == StEmit);
   assign bus.out_row   = r_cur_row;
   assign bus.out_last  = w_out_last;
   assign err_overflow  = r_err_overflow;
   assign err_order     = r_err_order;

endmodule

// File: tb/tb_coo_row_scheduler.sv
// Directed bench for coo_row_scheduler with N=4, NZN_ROW=2.
module tb_coo_row_scheduler;
   import coo_pkg::*;

   localparam int unsigned N   = 4;
   localparam int unsigned NZN = 2;
   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 16;
`ifdef COO_ROW_SCHED_ERR_EN
   localparam logic ErrEn = 1'b1;
`else
   localparam logic ErrEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_overflow;
   logic err_order;
   int   total = 0;
   int   bad   = 0;

   coo_row_scheduler_if #(.NZN_ROW(NZN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   coo_row_scheduler #(
      .N          (N),
      .NZN_ROW    (NZN),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .err_overflow (err_overflow),
      .err_order    (err_order)
   );

   always #5 clk = ~clk;

   // {data[1], data[0], col[1], col[0], count, row, last}
   function automatic logic [66:0] out_vec();
      return {bus.out_data, bus.out_col, bus.out_count, bus.out_row, bus.out_last};
   endfunction

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic send(input logic [7:0] d, input logic [15:0] r, input logic [15:0] c,
                       input logic keep, input logic last);
      int n = 0;
      bus.in_data  = d;
      bus.in_row   = r;
      bus.in_col   = c;
      bus.in_keep  = keep;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_r%0d: in_ready=%b required 1 within 20 cycles", r, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_keep  = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Waits for out_valid, checks the batch and in_ready, lets the handshake happen.
   task automatic expect_batch(input string name, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [15:0] c0, input logic [15:0] c1,
                               input logic [1:0] cnt, input logic [15:0] row,
                               input logic last);
      int          n = 0;
      logic [66:0] got;
      logic [66:0] want;
      want = {d1, d0, c1, c0, cnt, row, last};
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s_valid: out_valid=%b required 1 within 20 cycles", name,
                  bus.out_valid);
      end else begin
         got = out_vec();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL %s: got data=%h col=%h count=%0d row=%0d last=%b, required data=%h col=%h count=%0d row=%0d last=%b",
                     name, got[66:51], got[50:19], got[18:17], got[16:1], got[0],
                     want[66:51], want[50:19], want[18:17], want[16:1], want[0]);
         end
         total++;
         if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_in_ready: got %b required 0 during emit", name, bus.in_ready);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_keep   = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_data   = '0;
      bus.in_row    = '0;
      bus.in_col    = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.out_valid, out_vec(), err_overflow, err_order} !== 70'd0) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b out=%h errs=%b%b required all 0",
                  bus.out_valid, out_vec(), err_overflow, err_order);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL reset_ready: in_ready=%b out_valid=%b required 1 0", bus.in_ready,
                  bus.out_valid);
      end
   endtask

   task automatic test_basic();
      send(8'd5, 16'd0, 16'd1, 1'b1, 1'b0);
      send(8'd7, 16'd0, 16'd3, 1'b1, 1'b0);
      send(8'd2, 16'd1, 16'd0, 1'b1, 1'b1);
      expect_batch("basic_r0", 8'd5, 8'd7, 16'd1, 16'd3, 2'd2, 16'd0, 1'b0);
      expect_batch("basic_r1", 8'd2, 8'd0, 16'd0, 16'd0, 2'd1, 16'd1, 1'b0);
      expect_batch("basic_r2", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd2, 1'b0);
      expect_batch("basic_r3", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd3, 1'b1);
   endtask

   task automatic test_row_gap();
      send(8'd3, 16'd0, 16'd0, 1'b1, 1'b0);
      send(8'd4, 16'd2, 16'd1, 1'b1, 1'b1);
      expect_batch("gap_r0", 8'd3, 8'd0, 16'd0, 16'd0, 2'd1, 16'd0, 1'b0);
      expect_batch("gap_r1", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd1, 1'b0);
      expect_batch("gap_r2", 8'd4, 8'd0, 16'd1, 16'd0, 2'd1, 16'd2, 1'b0);
      expect_batch("gap_r3", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd3, 1'b1);
   endtask

   task automatic test_overflow();
      send(8'd1, 16'd0, 16'd0, 1'b1, 1'b0);
      send(8'd2, 16'd0, 16'd1, 1'b1, 1'b0);
      send(8'd3, 16'd0, 16'd2, 1'b1, 1'b1);
      expect_batch("ovf_r0", 8'd1, 8'd2, 16'd0, 16'd1, 2'd2, 16'd0, 1'b0);
      expect_batch("ovf_r1", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd1, 1'b0);
      expect_batch("ovf_r2", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd2, 1'b0);
      expect_batch("ovf_r3", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd3, 1'b1);
      total++;
      if ({err_overflow, err_order} !== {ErrEn, 1'b0}) begin
         bad++;
         $display("FAIL ovf_flags: overflow=%b order=%b required %b 0", err_overflow,
                  err_order, ErrEn);
      end
   endtask

   task automatic test_order();
      send(8'd1, 16'd2, 16'd0, 1'b1, 1'b0);
      expect_batch("ord_r0", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd0, 1'b0);
      expect_batch("ord_r1", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd1, 1'b0);
      send(8'd9, 16'd1, 16'd0, 1'b1, 1'b1);
      if (ErrEn) begin
         expect_batch("ord_r2", 8'd1, 8'd0, 16'd0, 16'd0, 2'd1, 16'd2, 1'b0);
      end else begin
         expect_batch("ord_r2", 8'd1, 8'd9, 16'd0, 16'd0, 2'd2, 16'd2, 1'b0);
      end
      expect_batch("ord_r3", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd3, 1'b1);
      // err_overflow from the previous matrix must still be held.
      total++;
      if ({err_overflow, err_order} !== {ErrEn, ErrEn}) begin
         bad++;
         $display("FAIL ord_flags: overflow=%b order=%b required %b %b", err_overflow,
                  err_order, ErrEn, ErrEn);
      end
   endtask

   task automatic test_empty_stall();
      send(8'd0, 16'd0, 16'd0, 1'b0, 1'b1);
      expect_batch("empty_r0", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd0, 1'b0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({bus.out_valid, out_vec()} !== {1'b1, 67'd2}) begin
            bad++;
            $display("FAIL stall_r1_c%0d: valid=%b out=%h required 1 %h", i, bus.out_valid,
                     out_vec(), 67'd2);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      expect_batch("empty_r1", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd1, 1'b0);
      expect_batch("empty_r2", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd2, 1'b0);
      expect_batch("empty_r3", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd3, 1'b1);
   endtask

   task automatic test_mid_reset();
      send(8'd5, 16'd0, 16'd0, 1'b1, 1'b0);
      send(8'd6, 16'd1, 16'd2, 1'b1, 1'b1);
      expect_batch("mrst_r0", 8'd5, 8'd0, 16'd0, 16'd0, 2'd1, 16'd0, 1'b0);
      bus.out_ready = 1'b0;
      total++;
      // r1 = {data 0,6; col 0,2; count 1; row 1; last 0}
      if ({bus.out_valid, out_vec()} !== {1'b1, 16'h0006, 32'h0000_0002, 2'd1, 16'd1, 1'b0})
      begin
         bad++;
         $display("FAIL mrst_r1_hold: valid=%b out=%h", bus.out_valid, out_vec());
      end
      #1 rst = 1'b1;
      @(negedge clk);
      total++;
      if ({bus.out_valid, out_vec(), err_overflow, err_order, bus.in_ready} !== 70'd1) begin
         bad++;
         $display("FAIL mrst_outputs: valid=%b out=%h errs=%b%b in_ready=%b required 0 0 00 1",
                  bus.out_valid, out_vec(), err_overflow, err_order, bus.in_ready);
      end
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      send(8'd8, 16'd0, 16'd1, 1'b1, 1'b1);
      expect_batch("mrst_new_r0", 8'd8, 8'd0, 16'd1, 16'd0, 2'd1, 16'd0, 1'b0);
      expect_batch("mrst_new_r1", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd1, 1'b0);
      expect_batch("mrst_new_r2", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd2, 1'b0);
      expect_batch("mrst_new_r3", 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 16'd3, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_row_gap();
      test_overflow();
      test_order();
      test_empty_stall();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
